// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding and sequencing control for the 5-stage RV32I pipeline
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instD,
  input  logic [31:0]      instX,
  input  logic [31:0]      instM,
  input  logic [31:0]      instW,
  input  logic             br_taken_X,
  input  logic             jal_D,
  output logic [2:0]       pc_sel,
  output logic             stall_F,
  output logic             stall_D,
  output logic             kill_D,
  output logic             bubble_X,
  output logic [1:0]       fwdA_X,
  output logic [1:0]       fwdB_X,
  output logic             byp1_D,
  output logic             byp2_D,
  output logic             vld_X,
  output logic             vld_M,
  output logic             vld_W,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [2:0] PC_PLUS4 = 3'd0;
  localparam logic [2:0] PC_ALU   = 3'd1;
  localparam logic [2:0] PC_HOLD  = 3'd2;
  localparam logic [2:0] PC_JAL   = 3'd3;
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_LOAD};
  endfunction
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction
  logic v_d_q, v_d_d, v_x_q, v_x_d, v_m_q, v_m_d, v_w_q, v_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic m_wr, w_wr, x_ld, lu, redir, jal_go;
  logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
  logic use1_d, use2_d, use1_x, use2_x;
  logic unused_bits;
  assign unused_bits = ^{instD[31:25], instD[14:7], instX[31:25], instX[14:12], instM[31:12], instW[31:12]};
  // Field extraction and per-stage producer qualification; x0 is never a producer
  always_comb begin
    rs1_d  = instD[19:15];
    rs2_d  = instD[24:20];
    rs1_x  = instX[19:15];
    rs2_x  = instX[24:20];
    rd_x   = instX[11:7];
    rd_m   = instM[11:7];
    rd_w   = instW[11:7];
    use1_d = uses_rs1(instD[6:0]);
    use2_d = uses_rs2(instD[6:0]);
    use1_x = uses_rs1(instX[6:0]);
    use2_x = uses_rs2(instX[6:0]);
    x_ld   = v_x_q && instX[6:0] == OP_LOAD && rd_x != 5'd0;
    m_wr   = v_m_q && writes_rd(instM[6:0]) && rd_m != 5'd0;
    w_wr   = v_w_q && writes_rd(instW[6:0]) && rd_w != 5'd0;
  end
  // Event detection: redirect beats load-use, load-use beats JAL
  always_comb begin
    redir  = br_taken_X && v_x_q;
    lu     = v_d_q && x_ld && ((use1_d && rs1_d == rd_x) || (use2_d && rs2_d == rd_x));
    jal_go = jal_D && v_d_q;
  end
  // PC-mux and pipeline-register controls from the winning event
  always_comb begin
    pc_sel   = redir ? PC_ALU : lu ? PC_HOLD : jal_go ? PC_JAL : PC_PLUS4;
    stall_F  = !redir && lu;
    stall_D  = !redir && lu;
    kill_D   = redir || (!lu && jal_go);
    bubble_X = redir || lu;
  end
  // Operand forwarding into X (M beats W) and regfile write-through bypass in D
  always_comb begin
    fwdA_X = !(v_x_q && use1_x) ? 2'd0 :
             (m_wr && rd_m == rs1_x) ? 2'd1 :
             (w_wr && rd_w == rs1_x) ? 2'd2 : 2'd0;
    fwdB_X = !(v_x_q && use2_x) ? 2'd0 :
             (m_wr && rd_m == rs2_x) ? 2'd1 :
             (w_wr && rd_w == rs2_x) ? 2'd2 : 2'd0;
    byp1_D = v_d_q && use1_d && w_wr && rd_w == rs1_d;
    byp2_D = v_d_q && use2_d && w_wr && rd_w == rs2_d;
  end
  // Next valid bits and event counters; counters wrap naturally
  always_comb begin
    v_d_d       = kill_D ? 1'b0 : stall_D ? v_d_q : 1'b1;
    v_x_d       = bubble_X ? 1'b0 : v_d_q;
    v_m_d       = v_x_q;
    v_w_d       = v_m_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_D);
    flush_cnt_d = flush_cnt_q + CNT_W'(kill_D);
  end
  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d_q       <= 1'b0;
      v_x_q       <= 1'b0;
      v_m_q       <= 1'b0;
      v_w_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_d_q       <= v_d_d;
      v_x_q       <= v_x_d;
      v_m_q       <= v_m_d;
      v_w_q       <= v_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign vld_X     = v_x_q;
  assign vld_M     = v_m_q;
  assign vld_W     = v_w_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage F/D/X/M/W RV32I pipeline.
- Tracks a valid bit per stage and detects RAW hazards from instD/instX/instM/instW.
- Drives PC-mux select, stall/kill controls for the pipeline registers, and forwarding selects for the X-stage ALU operand muxes and the D-stage register read.
- Counts stall and flush events for performance monitoring.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- instD  in  32  instruction word in D
- instX  in  32  instruction word in X
- instM  in  32  instruction word in M
- instW  in  32  instruction word in W
- br_taken_X  in  1  X-stage redirect: taken branch or JALR
- jal_D  in  1  instD is JAL and its target is ready (alutargetout)
- pc_sel  out  3  PCmux select: 0 PC+4, 1 ALU, 2 hold, 3 JAL target
- stall_F  out  1  hold PC
- stall_D  out  1  hold pcD/instD
- kill_D  out  1  load bubble (NOP 0x00000013) into instD
- bubble_X  out  1  load bubble into instX
- fwdA_X  out  2  ALU operand A source: 0 rs1X, 1 M-stage wb_out, 2 dataW
- fwdB_X  out  2  ALU operand B / rs2 source, same encoding as fwdA_X
- byp1_D  out  1  latch dataW instead of rs1_out into rs1X
- byp2_D  out  1  latch dataW instead of rs2_out into rs2X
- vld_X  out  1  stage X valid
- vld_M  out  1  stage M valid
- vld_W  out  1  stage W valid
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- State: vD, vX, vM, vW, stall_cnt, flush_cnt. On rst (async), all cleared to 0.
- All other outputs are combinational from state and inputs. With all valids at 0, every other output is 0 (pc_sel=0).
- Decode, taken from opcode [6:0]:
  - writes_rd: LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD.
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - is_load: 0000011.
- A stage S "produces r" when vS=1, writes_rd(instS)=1, rd(instS)=r and r!=0.
- Load-use (lu): vD, instX is a load that produces r, and instD uses r through rs1 or rs2.
- Priority per cycle:
  1. Redirect: br_taken_X and vX. Drive pc_sel=1, kill_D=1, bubble_X=1, flush_cnt+1.
  2. lu. Drive pc_sel=2, stall_F=1, stall_D=1, bubble_X=1, stall_cnt+1.
  3. JAL: jal_D and vD. Drive pc_sel=3, kill_D=1, flush_cnt+1.
  4. Otherwise drive pc_sel=0.
- A lower-priority event in the same cycle is dropped. A dropped jal_D is re-raised by the next cycle's instD.
- Valid update:
  - vD <= kill_D ? 0 : (stall_D ? vD : 1)
  - vX <= bubble_X ? 0 : vD
  - vM <= vX
  - vW <= vM
- Forwarding into X, per operand:
  - Select 1 if the operand is used and M produces the matching rs.
  - Otherwise select 2 if W produces it.
  - Otherwise select 0.
  - M has priority over W.
  - Selects are 0 when vX=0.
- D bypass: byp1_D = vD, uses_rs1(instD), W produces rs1(instD). byp2_D is the same for rs2. The regfile write lands on the same edge as the D→X read latch, so without this bypass the read is stale.
- After a lu stall, the load sits in M and the dependent instruction in X takes fwd=1, i.e. dmem_out via wb_out; the load needs no second stall cycle.
- x0 never forwards, never bypasses and never stalls.
- Counters wrap modulo 2^CNT_W.
- rst asserted mid-run empties the pipeline immediately. Fetch restarts with pc_sel=0 on the first cycle after release.

Test Plan:
1. Reset: pulse rst mid-stream → vld_X, vld_M, vld_W = 0, both counters 0, fwd and byp outputs 0, pc_sel=0 (async, before the next edge).
2. ALU forwarding: add x5,x1,x2 followed by add x6,x5,x3 → fwdA_X=1 when the second is in X. With one NOP between → fwdA_X=2. With two NOPs between → byp1_D=1 while the consumer is in D.
3. Load-use: lw x5,0(x1) then add x6,x5,x5 → exactly one cycle of stall_F=stall_D=bubble_X=1, pc_sel=2, stall_cnt=1. Next cycle fwdA_X=fwdB_X=1 and vld_X=1.
4. x0: addi x0,x0,1 then add x6,x0,x0 → fwdA_X=fwdB_X=0, no stall. lw x0 then a use of x0 → no stall.
5. Taken branch: beq in X with br_taken_X=1 → pc_sel=1, kill_D=1, bubble_X=1, flush_cnt=1. Next cycle vld_X=0, and no forwarding from the squashed slots two cycles later.
6. Simultaneous: br_taken_X=1 and jal_D=1 in the same cycle → pc_sel=1, flush_cnt +1 only. lu together with jal_D → pc_sel=2 that cycle, then pc_sel=3 the following cycle.
